// File: rtl/rv32i_forwarding_unit_if.sv
// Operand forwarding bundle between the read ports, the ALU stage
// and the downstream writeback sources.
interface rv32i_forwarding_unit_if #(
  parameter int XLEN    = 32,
  parameter int NUM_RS  = 2,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 32
);
  logic                    i_alu_valid;
  logic                    i_flush;
  logic [NUM_RS*XLEN-1:0]  i_rs_orig;
  logic [NUM_RS*5-1:0]     i_rs_addr;
  logic [NUM_RS-1:0]       i_rs_used;
  logic [NUM_RS*XLEN-1:0]  o_rs;
  logic                    o_force_stall;
  logic [NUM_FWD*5-1:0]    i_fwd_rd_addr;
  logic [NUM_FWD-1:0]      i_fwd_wr_rd;
  logic [NUM_FWD-1:0]      i_fwd_rd_valid;
  logic [NUM_FWD*XLEN-1:0] i_fwd_rd;
  logic [NUM_FWD-1:0]      i_fwd_ce;
  logic                    i_cnt_clr;
  logic                    o_stall_timeout;
  logic [CNT_W-1:0]        o_stall_events;
  logic [CNT_W-1:0]        o_stall_cycles;
  logic [CNT_W-1:0]        o_fwd_hits;

  modport master (
    output i_alu_valid, i_flush, i_rs_orig, i_rs_addr, i_rs_used,
    output i_fwd_rd_addr, i_fwd_wr_rd, i_fwd_rd_valid, i_fwd_rd,
    output i_fwd_ce, i_cnt_clr,
    input  o_rs, o_force_stall, o_stall_timeout,
    input  o_stall_events, o_stall_cycles, o_fwd_hits
  );

  modport slave (
    input  i_alu_valid, i_flush, i_rs_orig, i_rs_addr, i_rs_used,
    input  i_fwd_rd_addr, i_fwd_wr_rd, i_fwd_rd_valid, i_fwd_rd,
    input  i_fwd_ce, i_cnt_clr,
    output o_rs, o_force_stall, o_stall_timeout,
    output o_stall_events, o_stall_cycles, o_fwd_hits
  );
endinterface

// File: rtl/rv32i_forwarding_unit.sv
// Operand forwarding for NUM_RS read ports from NUM_FWD stages
// (stage 0 youngest), with stall FSM, watchdog and perf counters.
module rv32i_forwarding_unit #(
  parameter int XLEN          = 32,
  parameter int NUM_RS        = 2,
  parameter int NUM_FWD       = 2,
  parameter int STALL_TIMEOUT = 15,
  parameter int CNT_W         = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  rv32i_forwarding_unit_if.slave bus
);
  localparam int RUN_W = $clog2(STALL_TIMEOUT + 1);
  localparam int HIT_W = $clog2(NUM_RS + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STALL_TIMEOUT);
  localparam logic [RUN_W-1:0] RUN_ARM = RUN_W'(STALL_TIMEOUT - 1);

  typedef enum logic {
    IDLE,
    STALL
  } state_t;

  state_t state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             timeout_q;
  logic [CNT_W-1:0] events_q;
  logic [CNT_W-1:0] cycles_q;
  logic [CNT_W-1:0] hits_q;
  logic [CNT_W-1:0] hits_inc;

  logic [NUM_RS-1:0]      hit;
  logic [NUM_RS-1:0]      need_stall;
  logic [NUM_RS*XLEN-1:0] rs_sel;
  logic [HIT_W-1:0]       hit_cnt;
  logic [4:0]             addr;
  logic                   found;
  logic                   found_valid;
  logic                   force_stall;
  logic                   stall_start;

  // first matching stage wins, even when its value is not ready yet
  always_comb begin
    hit         = '0;
    need_stall  = '0;
    rs_sel      = '0;
    addr        = '0;
    found       = 1'b0;
    found_valid = 1'b0;
    for (int j = 0; j < NUM_RS; j++) begin
      addr        = bus.i_rs_addr[j*5 +: 5];
      found       = 1'b0;
      found_valid = 1'b0;
      rs_sel[j*XLEN +: XLEN] = bus.i_rs_orig[j*XLEN +: XLEN];
      if (addr == 5'd0) begin
        rs_sel[j*XLEN +: XLEN] = '0;
      end else begin
        for (int k = 0; k < NUM_FWD; k++) begin
          if (!found &&
              addr == bus.i_fwd_rd_addr[k*5 +: 5] &&
              bus.i_fwd_wr_rd[k] && bus.i_fwd_ce[k]) begin
            found       = 1'b1;
            found_valid = bus.i_fwd_rd_valid[k];
            rs_sel[j*XLEN +: XLEN] = bus.i_fwd_rd[k*XLEN +: XLEN];
          end
        end
      end
      hit[j]        = found;
      need_stall[j] = found && !found_valid &&
                      bus.i_rs_used[j] && bus.i_alu_valid;
    end
  end

  assign force_stall       = (|need_stall) && !bus.i_flush;
  assign bus.o_rs          = rs_sel;
  assign bus.o_force_stall = force_stall;

  always_comb begin
    hit_cnt = '0;
    for (int j = 0; j < NUM_RS; j++) begin
      hit_cnt = hit_cnt + HIT_W'(hit[j] & bus.i_rs_used[j]);
    end
  end

  assign hits_inc = (bus.i_alu_valid && !force_stall)
                  ? CNT_W'(hit_cnt) : '0;

  always_comb begin
    state_d     = state_q;
    stall_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (force_stall) begin
          state_d     = STALL;
          stall_start = 1'b1;
        end
      end
      STALL: begin
        if (!force_stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.i_flush) state_d = IDLE;
  end

  // flush already masks force_stall, so it also clears the run
  always_comb begin
    run_d = '0;
    if (force_stall) begin
      run_d = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
    end
  end

  function automatic logic [CNT_W-1:0] sat_add(
    input logic [CNT_W-1:0] a,
    input logic [CNT_W-1:0] b
  );
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      run_q     <= '0;
      timeout_q <= 1'b0;
      events_q  <= '0;
      cycles_q  <= '0;
      hits_q    <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      if (bus.i_cnt_clr) begin
        timeout_q <= 1'b0;
        events_q  <= '0;
        cycles_q  <= '0;
        hits_q    <= '0;
      end else begin
        if (force_stall && run_q == RUN_ARM) timeout_q <= 1'b1;
        if (stall_start) events_q <= sat_add(events_q, CNT_W'(1));
        if (force_stall) cycles_q <= sat_add(cycles_q, CNT_W'(1));
        hits_q <= sat_add(hits_q, hits_inc);
      end
    end
  end

  assign bus.o_stall_timeout = timeout_q;
  assign bus.o_stall_events  = events_q;
  assign bus.o_stall_cycles  = cycles_q;
  assign bus.o_fwd_hits      = hits_q;
endmodule
